rob_wb_arbiter: RTL and testbench

//  Shares the single ROB status writeback port (wb_e_/wb_rob_id/wb_exp_/...) between REQ execution units.

---
 rtl/rob_wb_arbiter.sv | 144 ++++++++++++++
 tb/tb_rob_wb_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_wb_arbiter.sv
// rob_wb_arbiter: shares the single ROB status writeback port between REQ execution units.
// Round-robin grant by default; define WB_ARB_FIXED_PRIO_EN for lowest-index-first priority.
`ifndef RobDepth
`define RobDepth 16
`endif

module rob_wb_arbiter #(
    parameter int  REQ       = 4,
    parameter int  ROB_DEPTH = `RobDepth,
    parameter type ExpCode_t = logic [3:0],
    localparam int ROB       = $clog2(ROB_DEPTH),
    localparam int SRC       = $clog2(REQ)
) (
    input  logic                    clk,
    input  logic                    reset_,
    input  logic                    flush_,
    input  logic [REQ-1:0]          req_e_,
    input  logic [REQ-1:0][ROB-1:0] req_rob_id,
    input  logic [REQ-1:0]          req_exp_,
    input  ExpCode_t [REQ-1:0]      req_exp_code,
    input  logic [REQ-1:0]          req_pred_miss_,
    input  logic [REQ-1:0]          req_jump_miss_,
    output logic [REQ-1:0]          req_ready,
    output logic                    wb_e_,
    output logic [ROB-1:0]          wb_rob_id,
    output logic                    wb_exp_,
    output ExpCode_t                wb_exp_code,
    output logic                    wb_pred_miss_,
    output logic                    wb_jump_miss_,
    output logic [SRC-1:0]          wb_src
);

    typedef struct packed {
        logic [ROB-1:0] rob_id;
        logic           exp_;
        ExpCode_t       exp_code;
        logic           pred_miss_;
        logic           jump_miss_;
    } slot_t;

    logic [REQ-1:0] slot_valid;
    slot_t [REQ-1:0] slot_q;
    slot_t [REQ-1:0] req_slot;
    logic [REQ-1:0] grant;
    logic           grant_any;
    logic [SRC-1:0] grant_idx;

    always_comb begin
        req_slot = '0;
        for (int i = 0; i < REQ; i++) begin
            req_slot[i].rob_id     = req_rob_id[i];
            req_slot[i].exp_       = req_exp_[i];
            req_slot[i].exp_code   = req_exp_code[i];
            req_slot[i].pred_miss_ = req_pred_miss_[i];
            req_slot[i].jump_miss_ = req_jump_miss_[i];
        end
    end

`ifdef WB_ARB_FIXED_PRIO_EN
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < REQ; k++) begin
            if (!grant_any && slot_valid[SRC'(k)]) begin
                grant_any = 1'b1;
                grant_idx = SRC'(k);
            end
        end
    end
`else
    logic [SRC-1:0] rr_ptr;

    // Scan starts at rr_ptr; explicit modulo keeps non-power-of-2 REQ correct.
    always_comb begin
        int idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < REQ; k++) begin
            idx = (int'(rr_ptr) + k) % REQ;
            if (!grant_any && slot_valid[SRC'(idx)]) begin
                grant_any = 1'b1;
                grant_idx = SRC'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            rr_ptr <= '0;
        end else if (flush_ && grant_any) begin
            rr_ptr <= (int'(grant_idx) == REQ - 1) ? '0 : grant_idx + 1'b1;
        end
    end
`endif

    always_comb begin
        grant = '0;
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // A slot being drained this cycle may be refilled at the same edge.
    assign req_ready = ~slot_valid | grant;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            slot_valid <= '0;
            slot_q     <= '0;
        end else if (!flush_) begin
            slot_valid <= '0;
        end else begin
            for (int i = 0; i < REQ; i++) begin
                if (!req_e_[i] && req_ready[i]) begin
                    slot_valid[i] <= 1'b1;
                    slot_q[i]     <= req_slot[i];
                end else if (grant[i]) begin
                    slot_valid[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        wb_e_         = 1'b1;
        wb_rob_id     = '0;
        wb_exp_       = 1'b1;
        wb_exp_code   = '0;
        wb_pred_miss_ = 1'b1;
        wb_jump_miss_ = 1'b1;
        wb_src        = '0;
        if (grant_any) begin
            wb_e_         = 1'b0;
            wb_rob_id     = slot_q[grant_idx].rob_id;
            wb_exp_       = slot_q[grant_idx].exp_;
            wb_exp_code   = slot_q[grant_idx].exp_code;
            wb_pred_miss_ = slot_q[grant_idx].pred_miss_;
            wb_jump_miss_ = slot_q[grant_idx].jump_miss_;
            wb_src        = grant_idx;
        end
    end

endmodule

// File: tb/tb_rob_wb_arbiter.sv
// tb_rob_wb_arbiter: directed and random stimulus; a queue-based reference model predicts
// every writeback, and a separate monitor compares the DUT against it each cycle.
`timescale 1ns/1ps

module tb_rob_wb_arbiter;

    localparam int REQ = 4;
    localparam int ROB_DEPTH = 16;
    localparam int ROB = 4;
    localparam int SRC = 2;
    localparam logic [3:0] EXP_NONE = 4'h0;
    localparam logic [3:0] EXP_I_MISS_ALIGN = 4'h1;

    typedef struct {
        logic [ROB-1:0] rob_id;
        logic           exp_;
        logic [3:0]     code;
        logic           pm_;
        logic           jm_;
    } pay_t;

    typedef struct {
        int   cyc;
        int   src;
        pay_t p;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    reset_ = 1'b1;
    logic                    flush_ = 1'b1;
    logic [REQ-1:0]          req_e_ = '1;
    logic [REQ-1:0][ROB-1:0] req_rob_id = '0;
    logic [REQ-1:0]          req_exp_ = '1;
    logic [REQ-1:0][3:0]     req_exp_code = '0;
    logic [REQ-1:0]          req_pred_miss_ = '1;
    logic [REQ-1:0]          req_jump_miss_ = '1;
    logic [REQ-1:0]          req_ready;
    logic                    wb_e_;
    logic [ROB-1:0]          wb_rob_id;
    logic                    wb_exp_;
    logic [3:0]              wb_exp_code;
    logic                    wb_pred_miss_;
    logic                    wb_jump_miss_;
    logic [SRC-1:0]          wb_src;

    // Reference model: set of occupied slots plus the "next to look at" pointer.
    exp_t           exp_q[$];
    bit             m_valid[REQ];
    pay_t           m_pay[REQ];
    int             m_rr = 0;
    logic [REQ-1:0] exp_ready = '1;
    pay_t           stim[REQ];
    logic [REQ-1:0] stim_e_ = '1;
    int             cyc = 0;
    int             n_checks = 0;
    int             n_fail = 0;

    rob_wb_arbiter #(.REQ(REQ), .ROB_DEPTH(ROB_DEPTH)) dut (
        .clk(clk), .reset_(reset_), .flush_(flush_), .req_e_(req_e_),
        .req_rob_id(req_rob_id), .req_exp_(req_exp_), .req_exp_code(req_exp_code),
        .req_pred_miss_(req_pred_miss_), .req_jump_miss_(req_jump_miss_),
        .req_ready(req_ready), .wb_e_(wb_e_), .wb_rob_id(wb_rob_id), .wb_exp_(wb_exp_),
        .wb_exp_code(wb_exp_code), .wb_pred_miss_(wb_pred_miss_),
        .wb_jump_miss_(wb_jump_miss_), .wb_src(wb_src)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    function automatic int model_grant();
`ifdef WB_ARB_FIXED_PRIO_EN
        for (int i = 0; i < REQ; i++) if (m_valid[i]) return i;
`else
        for (int k = 0; k < REQ; k++) if (m_valid[(m_rr + k) % REQ]) return (m_rr + k) % REQ;
`endif
        return -1;
    endfunction

    function automatic pay_t rand_pay();
        pay_t p;
        p.rob_id = ROB'($urandom_range(0, ROB_DEPTH - 1));
        p.exp_   = ($urandom_range(0, 3) != 0);
        p.code   = 4'($urandom_range(0, 9));
        p.pm_    = ($urandom_range(0, 3) != 0);
        p.jm_    = ($urandom_range(0, 3) != 0);
        return p;
    endfunction

    function automatic pay_t mk_pay(input int id);
        pay_t p;
        p.rob_id = ROB'(id);
        p.exp_   = 1'b1;
        p.code   = EXP_NONE;
        p.pm_    = 1'b1;
        p.jm_    = 1'b1;
        return p;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, req);
        end
    endtask

    // One clock of stimulus: drive the inputs, step the model across the coming edge,
    // and record what the DUT must present in the following cycle.
    task automatic apply_stimulus(input logic fl_);
        int g;
        @(negedge clk);
        #1;
        flush_ = fl_;
        req_e_ = stim_e_;
        for (int i = 0; i < REQ; i++) begin
            req_rob_id[i]     = stim[i].rob_id;
            req_exp_[i]       = stim[i].exp_;
            req_exp_code[i]   = stim[i].code;
            req_pred_miss_[i] = stim[i].pm_;
            req_jump_miss_[i] = stim[i].jm_;
        end
        g = model_grant();
        if (!fl_) begin
            for (int i = 0; i < REQ; i++) m_valid[i] = 1'b0;
        end else begin
            for (int i = 0; i < REQ; i++) begin
                if (!stim_e_[i] && (!m_valid[i] || g == i)) begin
                    m_valid[i] = 1'b1;
                    m_pay[i]   = stim[i];
                end else if (g == i) begin
                    m_valid[i] = 1'b0;
                end
            end
            if (g >= 0) m_rr = (g + 1) % REQ;
        end
        g = model_grant();
        for (int i = 0; i < REQ; i++) exp_ready[i] = !m_valid[i] || (g == i);
        if (g >= 0) exp_q.push_back('{cyc + 1, g, m_pay[g]});
    endtask

    task automatic apply_reset(input int n);
        @(negedge clk);
        #1;
        reset_ = 1'b0;
        flush_ = 1'b1;
        req_e_ = '1;
        stim_e_ = '1;
        for (int i = 0; i < REQ; i++) m_valid[i] = 1'b0;
        m_rr = 0;
        exp_ready = '1;
        repeat (n) @(negedge clk);
        #1;
        reset_ = 1'b1;
    endtask

    task automatic idle(input int n);
        stim_e_ = '1;
        repeat (n) apply_stimulus(1'b1);
    endtask

    // Monitor: compares whatever the DUT presents against the oldest due prediction.
    task automatic check_output();
        exp_t e;
        bit   due;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            chk("stale_expect", 32'(e.cyc), 32'(cyc));
        end
        due = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
        chk("wb_e_", 32'(wb_e_), due ? 32'd0 : 32'd1);
        if (due) begin
            e = exp_q.pop_front();
            if (wb_e_ === 1'b0) begin
                chk("wb_src", 32'(wb_src), 32'(e.src));
                chk("wb_rob_id", 32'(wb_rob_id), 32'(e.p.rob_id));
                chk("wb_exp_code", 32'(wb_exp_code), 32'(e.p.code));
                chk("wb_flags", 32'({wb_exp_, wb_pred_miss_, wb_jump_miss_}),
                    32'({e.p.exp_, e.p.pm_, e.p.jm_}));
            end
        end else if (wb_e_ === 1'b1) begin
            chk("idle_data", 32'({wb_rob_id, wb_src, wb_exp_code, wb_exp_, wb_pred_miss_, wb_jump_miss_}),
                32'({4'h0, 2'h0, 4'h0, 3'b111}));
        end
    endtask

    always @(negedge clk) check_output();

    initial begin
        for (int i = 0; i < REQ; i++) begin
            stim[i] = mk_pay(0);
            m_valid[i] = 1'b0;
            m_pay[i] = mk_pay(0);
        end
        #1 reset_ = 1'b0;
        apply_reset(3);

        $display("[TB] idle after reset");
        idle(10);

        $display("[TB] single request on unit 2");
        stim_e_ = 4'b1011;
        stim[2] = mk_pay(5);
        apply_stimulus(1'b1);
        idle(3);

        $display("[TB] all units requesting every cycle");
        for (int i = 0; i < REQ; i++) stim[i] = mk_pay(i + 1);
        stim_e_ = 4'b0000;
        repeat (12) apply_stimulus(1'b1);
        idle(6);

        $display("[TB] granted slot refilled in the same cycle");
        stim_e_ = 4'b1101;
        stim[1] = mk_pay(7);
        apply_stimulus(1'b1);
        stim[1] = mk_pay(9);
        apply_stimulus(1'b1);
        idle(3);

        $display("[TB] flush with slots 0 and 3 full");
        stim_e_ = 4'b0110;
        stim[0] = mk_pay(2);
        stim[3] = mk_pay(11);
        apply_stimulus(1'b1);
        stim_e_ = 4'b1101;
        stim[1] = mk_pay(6);
        apply_stimulus(1'b0);
        idle(2);
        for (int i = 0; i < REQ; i++) stim[i] = mk_pay(12 + i);
        stim_e_ = 4'b0000;
        repeat (5) apply_stimulus(1'b1);
        idle(6);

        $display("[TB] exception and mispredict pass-through");
        stim_e_ = 4'b1110;
        stim[0] = mk_pay(3);
        stim[0].exp_ = 1'b0;
        stim[0].code = EXP_I_MISS_ALIGN;
        stim[0].pm_ = 1'b0;
        apply_stimulus(1'b1);
        idle(3);

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            if (n == 200) begin
                apply_reset(2);
            end else begin
                for (int i = 0; i < REQ; i++) begin
                    stim_e_[i] = ($urandom_range(0, 2) == 0);
                    stim[i] = rand_pay();
                end
                apply_stimulus($urandom_range(0, 15) != 0);
            end
        end
        idle(6);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
